bitscan_encoder: RTL and testbench

Sequential encoder, the inverse of the team's one-hot decoder. It accepts an N-bit request vector and emits the binary index of every set bit, lowest index first, one index per output beat. It uses valid/ready handshakes on both sides. It sits between status or request collectors and any consumer that needs binary indices, such as interrupt and grant logging.

---
 rtl/coding_pkg.sv | 29 ++
 rtl/lsb_priority_encoder.sv | 23 ++
 rtl/bitscan_encoder.sv | 103 ++++++++++
 tb/tb_bitscan_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coding_pkg.sv
// Shared definitions for the binary coding blocks (encoders/decoders).
// Provides the index-width helper and the bitscan encoder state encoding.
package coding_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_ZERO = 2'd2
  } state_t;

  // Ceiling log2, with a floor of 1 bit so a 1-entry index still has width.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational priority encoder: index of the lowest set bit of vec,
// plus a flag telling whether any bit is set (idx is 0 when none is).
module lsb_priority_encoder
  import coding_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any_set
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx     = '0;
    any_set = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/bitscan_encoder.sv
// Sequential bit-scan encoder: accepts an N-bit request vector and emits the
// index of each set bit, lowest first, one beat per handshake.
module bitscan_encoder
  import coding_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_zero
);

  localparam logic [N-1:0] LSB_ONE = {{(N - 1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [N-1:0]     pending_r;
  logic [IDX_W-1:0] lsb_idx_s;
  logic             any_set_s;
  logic             busy_s;
  logic             zero_flag_s;
  logic             onehot_s;
  logic             accept_s;
  logic             beat_s;

  lsb_priority_encoder #(
    .N (N)
  ) u_lsb_enc (
    .vec     (pending_r),
    .idx     (lsb_idx_s),
    .any_set (any_set_s)
  );

  // Decode the state register into the busy/zero_flag view used by the datapath.
  always_comb begin
    busy_s      = 1'b0;
    zero_flag_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s      = 1'b0;
        zero_flag_s = 1'b0;
      end
      ST_SCAN: begin
        busy_s      = 1'b1;
        zero_flag_s = 1'b0;
      end
      ST_ZERO: begin
        busy_s      = 1'b1;
        zero_flag_s = 1'b1;
      end
      default: begin
        busy_s      = 1'b0;
        zero_flag_s = 1'b0;
      end
    endcase
  end

  assign onehot_s  = any_set_s & ((pending_r & (pending_r - LSB_ONE)) == '0);

  assign out_valid = busy_s;
  assign out_zero  = zero_flag_s;
  assign out_last  = zero_flag_s | onehot_s;
  assign out_idx   = zero_flag_s ? '0 : lsb_idx_s;

  // Taking the last beat frees the slot in the same cycle, so vectors chain without a bubble.
  assign in_ready  = ~rst & (~busy_s | (out_ready & out_last));
  assign accept_s  = in_valid & in_ready;
  assign beat_s    = busy_s & out_ready;

  // State and pending-bit update; a new accept overrides completion of the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pending_r <= '0;
    end else if (accept_s) begin
      if (in_vec != '0) begin
        state_r   <= ST_SCAN;
        pending_r <= in_vec;
      end else begin
        state_r   <= ST_ZERO;
        pending_r <= '0;
      end
    end else if (beat_s) begin
      pending_r <= pending_r & (pending_r - LSB_ONE);
      if (out_last) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_r;
      end
    end else begin
      state_r   <= state_r;
      pending_r <= pending_r;
    end
  end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Directed testbench for bitscan_encoder (N=4): reset, scan, zero vector,
// backpressure, back-to-back vectors and reset in the middle of a scan.
module tb_bitscan_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] in_vec;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       out_zero;

  int n_cmp;
  int n_fail;

  bitscan_encoder #(
    .N (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unknown request bits are outside the contract.
  always @(posedge clk) begin
    if (in_valid === 1'b1 && rst === 1'b0) begin
      assert (!$isunknown(in_vec)) else $error("in_vec has unknown bits while in_valid");
    end
  end

  // Beat tuple {valid, idx, last, zero}.
  function automatic logic [4:0] beat();
    return {out_valid, out_idx, out_last, out_zero};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_vec = 4'b1111; out_ready = 1'b1;
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", c, in_ready);
      end
      n_cmp++;
      if (beat() !== 5'b0_00_0_0) begin
        n_fail++; $display("FAIL reset_outputs cyc%0d: got %b want 00000", c, beat());
      end
      next_cycle();
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
    next_cycle();
  endtask

  task automatic test_basic_scan();
    in_vec = 4'b1010; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b1_01_0_0) begin
      n_fail++; $display("FAIL basic_beat0: got %b want 10100", beat());
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_in_ready0: got %b want 0", in_ready);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b1_11_1_0) begin
      n_fail++; $display("FAIL basic_beat1: got %b want 11110", beat());
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_in_ready1: got %b want 1", in_ready);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_zero_vector();
    in_vec = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b1_00_1_1) begin
      n_fail++; $display("FAIL zero_beat: got %b want 10011", beat());
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_idx  [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    logic       exp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       rdy      [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    in_vec = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      out_ready = rdy[i];
      // Offer a different vector during the stalls; it must be ignored.
      in_valid  = (i == 1 || i == 2);
      in_vec    = 4'b0101;
      @(negedge clk);
      n_cmp++;
      if (beat() !== {1'b1, exp_idx[i], exp_last[i], 1'b0}) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %b want %b", i, beat(), {1'b1, exp_idx[i], exp_last[i], 1'b0});
      end
      if (i == 1 || i == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_done: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    in_vec = 4'b1000; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_vec = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b1_11_1_0) begin
      n_fail++; $display("FAIL b2b_beat0: got %b want 11110", beat());
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready);
    end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b1_00_1_0) begin
      n_fail++; $display("FAIL b2b_beat1: got %b want 10010", beat());
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    in_vec = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b1_00_0_0) begin
      n_fail++; $display("FAIL mid_beat0: got %b want 10000", beat());
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b1_01_0_0) begin
      n_fail++; $display("FAIL mid_beat1: got %b want 10100", beat());
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b0_00_0_0) begin
      n_fail++; $display("FAIL mid_after_rst: got %b want 00000", beat());
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_after_rst_in_ready: got %b want 1", in_ready);
    end
    in_vec = 4'b0100; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (beat() !== 5'b1_10_1_0) begin
      n_fail++; $display("FAIL mid_new_beat: got %b want 11010", beat());
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_new_done: out_valid got %b want 0", out_valid);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_vec    = 4'b0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_scan();
    test_zero_vector();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
